// File: rtl/rom_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_uart_tx_if
// Description : Signal bundle between the ROM-driven UART transmitter and its
//               environment (requester, external ROM and serial line).
//               start    - request to send one message
//               rom_addr - byte address presented to the external ROM
//               rom_data - ROM output for the address seen one edge earlier
//               tx       - 8N1 serial line, LSB first, idle high
//               busy     - transmitter is not idle
//               done     - one-cycle pulse at the end of a message
//               modport slave  : the transmitter side
//               modport master : the requester / ROM side
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_uart_tx_if #(
   parameter int ADDR_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              tx;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output rom_data,
      input  rom_addr,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  rom_data,
      output rom_addr,
      output tx,
      output busy,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/rom_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : rom_uart_tx
// Description : Sends a fixed-length message read byte by byte from an
//               external ROM (one-cycle registered read) over an 8N1 UART
//               line. One start request sends MSG_LEN bytes from address 0
//               upward, then pulses done for one cycle.
// Ports       : CLOCK   - single clock, rising edge
//               RESET_N - asynchronous active-low reset
//               bus     - rom_uart_tx_if.slave (start, rom_addr, rom_data,
//                         tx, busy, done)
// Parameters  : CLKS_PER_BIT - clock cycles per serial bit
//               MSG_LEN      - bytes per message
//               ADDR_W       - ROM address width
// Revision    : 1.0 - initial release
// ============================================================================
module rom_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int MSG_LEN      = 10,
   parameter int ADDR_W       = 4
) (
   input  wire logic     CLOCK,
   input  wire logic     RESET_N,
   rom_uart_tx_if.slave  bus
);

   // Baud counter must hold CLKS_PER_BIT-1; keep at least one bit.
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  baud_cnt, baud_nx;
   logic [2:0]        bit_cnt, bit_nx;
   logic [7:0]        shreg, shreg_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic              tx_q, tx_nx;
   logic              done_q, done_nx;
   logic              baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         addr_q   <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_cnt  <= bit_nx;
         shreg    <= shreg_nx;
         addr_q   <= addr_nx;
         tx_q     <= tx_nx;
         done_q   <= done_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      addr_nx  = addr_q;
      done_nx  = 1'b0;
      tx_nx    = 1'b1;

      case (state)
         IDLE: begin
            if (bus.start) begin
               addr_nx  = '0;
               state_nx = FETCH;
            end
         end

         // ROM is presented the address here; its data arrives during LOAD.
         FETCH: begin
            state_nx = LOAD;
         end

         LOAD: begin
            shreg_nx = bus.rom_data;
            state_nx = START;
         end

         START: begin
            baud_nx = baud_last ? '0 : baud_cnt + CNT_W'(1);
            if (baud_last) begin
               state_nx = DATA;
            end
         end

         DATA: begin
            baud_nx = baud_last ? '0 : baud_cnt + CNT_W'(1);
            if (baud_last) begin
               shreg_nx = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) begin
                  bit_nx   = '0;
                  state_nx = STOP;
               end else begin
                  bit_nx = bit_cnt + 3'd1;
               end
            end
         end

         STOP: begin
            baud_nx = baud_last ? '0 : baud_cnt + CNT_W'(1);
            if (baud_last) begin
               if (addr_q >= ADDR_LAST) begin
                  // Last byte: address holds so the final address stays visible.
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  addr_nx  = addr_q + ADDR_W'(1);
                  state_nx = FETCH;
               end
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      // Every state starts its bit period from a clean count.
      if (state_nx != state) begin
         baud_nx = '0;
      end

      // tx is decoded from the upcoming state so the registered line changes
      // on the same edge as the state it belongs to.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shreg_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

   assign bus.rom_addr = addr_q;
   assign bus.tx       = tx_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_uart_tx
// Description : Self-checking bench for rom_uart_tx. Two instances share the
//               clock and reset: one with a 10-byte message, one with a
//               single-byte message. Expected line activity is computed from
//               the message bytes: each byte takes 2 idle-high cycles, a start
//               bit, 8 data bits LSB first and a stop bit, CLKS_PER_BIT each.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_uart_tx;

   localparam int C = 4;
   localparam int L = 10;
   localparam int P = 2 + 10 * C;   // cycles per byte, fetch to end of stop

   logic CLOCK   = 1'b0;
   logic RESET_N = 1'b1;

   rom_uart_tx_if #(.ADDR_W(4)) if0 ();
   rom_uart_tx_if #(.ADDR_W(4)) if1 ();

   rom_uart_tx #(.CLKS_PER_BIT(C), .MSG_LEN(L), .ADDR_W(4)) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (if0.slave)
   );

   rom_uart_tx #(.CLKS_PER_BIT(C), .MSG_LEN(1), .ADDR_W(4)) dut1 (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (if1.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int e0          = -1000;
   bit corrupt     = 1'b0;

   logic [7:0] rom0 [16];
   logic [7:0] rom1 [16];
   logic [7:0] q0, q1;

   always #5 CLOCK = ~CLOCK;

   // External ROMs with one registered read stage.
   always @(posedge CLOCK) begin
      cyc <= cyc + 1;
      q0  <= rom0[if0.rom_addr];
      q1  <= rom1[if1.rom_addr];
   end

   // In corrupt mode the ROM bus carries 8'hFF except during the LOAD cycle
   // of each byte, which sits one cycle after the byte's fetch edge.
   always @(negedge CLOCK) begin
      if (corrupt && (((cyc - e0) % P) != 1))
         if0.rom_data = 8'hFF;
      else
         if0.rom_data = q0;
      if1.rom_data = q1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   // Expected line level r cycles into a byte period.
   function automatic logic exp_tx(input logic [7:0] b, input int r);
      int slot;
      if (r < 2) return 1'b1;
      slot = (r - 2) / C;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // Launches a message on instance sel and checks every cycle of it.
   // pulse_at : sample index at which a one-cycle start pulse is injected
   // keep     : leave start high after the message is accepted
   // abort_at : sample index at which reset is asserted and the run stops
   task automatic run_message(input int sel, input int pulse_at, input bit keep,
                              input int abort_at, input string tag);
      int         nb;
      logic [7:0] b;
      logic       et, otx, obusy, odone, st;
      logic [3:0] ea, oaddr;
      nb = sel ? 1 : L;
      if (sel != 0) if1.start = 1'b1; else if0.start = 1'b1;
      e0 = cyc + 1;
      for (int i = 0; i < nb * P; i++) begin
         @(negedge CLOCK);
         b     = (sel != 0) ? rom1[i / P] : rom0[i / P];
         et    = exp_tx(b, i % P);
         ea    = 4'(i / P);
         otx   = (sel != 0) ? if1.tx       : if0.tx;
         obusy = (sel != 0) ? if1.busy     : if0.busy;
         odone = (sel != 0) ? if1.done     : if0.done;
         oaddr = (sel != 0) ? if1.rom_addr : if0.rom_addr;
         vectors += 4;
         if (otx !== et) begin
            miscompares++;
            $display("FAIL %s tx i=%0d got=%b want=%b", tag, i, otx, et);
         end
         if (obusy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy i=%0d got=%b want=1", tag, i, obusy);
         end
         if (odone !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done i=%0d got=%b want=0", tag, i, odone);
         end
         if (oaddr !== ea) begin
            miscompares++;
            $display("FAIL %s rom_addr i=%0d got=%0d want=%0d", tag, i, oaddr, ea);
         end
         if (i == abort_at) begin
            RESET_N = 1'b0;
            #1;
            vectors += 4;
            if (if0.tx !== 1'b1) begin
               miscompares++;
               $display("FAIL %s reset tx got=%b want=1", tag, if0.tx);
            end
            if (if0.busy !== 1'b0) begin
               miscompares++;
               $display("FAIL %s reset busy got=%b want=0", tag, if0.busy);
            end
            if (if0.done !== 1'b0) begin
               miscompares++;
               $display("FAIL %s reset done got=%b want=0", tag, if0.done);
            end
            if (if0.rom_addr !== 4'd0) begin
               miscompares++;
               $display("FAIL %s reset rom_addr got=%0d want=0", tag, if0.rom_addr);
            end
            return;
         end
         st = keep || (i == pulse_at);
         if (sel != 0) if1.start = st; else if0.start = st;
      end
      @(negedge CLOCK);
      otx   = (sel != 0) ? if1.tx       : if0.tx;
      obusy = (sel != 0) ? if1.busy     : if0.busy;
      odone = (sel != 0) ? if1.done     : if0.done;
      oaddr = (sel != 0) ? if1.rom_addr : if0.rom_addr;
      vectors += 4;
      if (odone !== 1'b1) begin
         miscompares++;
         $display("FAIL %s end done got=%b want=1", tag, odone);
      end
      if (obusy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end busy got=%b want=0", tag, obusy);
      end
      if (otx !== 1'b1) begin
         miscompares++;
         $display("FAIL %s end tx got=%b want=1", tag, otx);
      end
      if (oaddr !== 4'(nb - 1)) begin
         miscompares++;
         $display("FAIL %s end rom_addr got=%0d want=%0d", tag, oaddr, nb - 1);
      end
   endtask

   // Checks that instance 0 stays idle for n cycles.
   task automatic check_idle0(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK);
         vectors += 3;
         if (if0.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle busy i=%0d got=%b want=0", tag, i, if0.busy);
         end
         if (if0.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle done i=%0d got=%b want=0", tag, i, if0.done);
         end
         if (if0.tx !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle tx i=%0d got=%b want=1", tag, i, if0.tx);
         end
      end
   endtask

   task automatic randomize_rom0();
      for (int i = 0; i < 16; i++) rom0[i] = 8'($urandom);
   endtask

   task automatic test_reset();
      #2 RESET_N = 1'b0;
      #1;
      vectors += 8;
      if (if0.tx !== 1'b1)       begin miscompares++; $display("FAIL reset tx0 got=%b want=1", if0.tx); end
      if (if0.busy !== 1'b0)     begin miscompares++; $display("FAIL reset busy0 got=%b want=0", if0.busy); end
      if (if0.done !== 1'b0)     begin miscompares++; $display("FAIL reset done0 got=%b want=0", if0.done); end
      if (if0.rom_addr !== 4'd0) begin miscompares++; $display("FAIL reset addr0 got=%0d want=0", if0.rom_addr); end
      if (if1.tx !== 1'b1)       begin miscompares++; $display("FAIL reset tx1 got=%b want=1", if1.tx); end
      if (if1.busy !== 1'b0)     begin miscompares++; $display("FAIL reset busy1 got=%b want=0", if1.busy); end
      if (if1.done !== 1'b0)     begin miscompares++; $display("FAIL reset done1 got=%b want=0", if1.done); end
      if (if1.rom_addr !== 4'd0) begin miscompares++; $display("FAIL reset addr1 got=%0d want=0", if1.rom_addr); end
      repeat (3) @(negedge CLOCK);
      RESET_N = 1'b1;
      check_idle0(3, "post_reset");
   endtask

   task automatic test_fixed_message();
      rom0[0] = 8'd66;
      for (int i = 1; i < 16; i++) rom0[i] = 8'd139;
      run_message(0, -1, 1'b0, -1, "fixed");
      check_idle0(2, "fixed");
   endtask

   task automatic test_random_messages();
      for (int k = 0; k < 2; k++) begin
         randomize_rom0();
         run_message(0, -1, 1'b0, -1, "random");
         check_idle0(1 + int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_start_ignored();
      randomize_rom0();
      run_message(0, 3 * P + 2 + 3 * C, 1'b0, -1, "ignore");
      check_idle0(4, "ignore");
   endtask

   task automatic test_reset_midframe();
      randomize_rom0();
      rom0[2] = rom0[2] & 8'hDF;   // bit 5 low so the abort is visible on tx
      run_message(0, -1, 1'b0, 2 * P + 2 + 6 * C + 1, "abort");
      @(negedge CLOCK);
      RESET_N = 1'b1;
      check_idle0(5, "abort");
      run_message(0, -1, 1'b0, -1, "after_abort");
      check_idle0(1, "after_abort");
   endtask

   task automatic test_start_held();
      randomize_rom0();
      run_message(0, -1, 1'b1, -1, "held1");
      run_message(0, -1, 1'b1, -1, "held2");
      run_message(0, -1, 1'b0, -1, "held3");
      check_idle0(3, "held");
   endtask

   task automatic test_msg_len1();
      rom1[0] = 8'hA5;
      for (int i = 1; i < 16; i++) rom1[i] = 8'h3C;
      run_message(1, -1, 1'b0, -1, "len1");
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK);
         vectors += 3;
         if (if1.done !== 1'b0)     begin miscompares++; $display("FAIL len1 idle done got=%b want=0", if1.done); end
         if (if1.busy !== 1'b0)     begin miscompares++; $display("FAIL len1 idle busy got=%b want=0", if1.busy); end
         if (if1.rom_addr !== 4'd0) begin miscompares++; $display("FAIL len1 idle addr got=%0d want=0", if1.rom_addr); end
      end
   endtask

   task automatic test_rom_glitch();
      randomize_rom0();
      for (int i = 0; i < 16; i++) if (rom0[i] == 8'hFF) rom0[i] = 8'h5A;
      corrupt = 1'b1;
      run_message(0, -1, 1'b0, -1, "glitch");
      corrupt = 1'b0;
      check_idle0(2, "glitch");
   endtask

   initial begin
      if0.start = 1'b0;
      if1.start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rom0[i] = 8'h00;
         rom1[i] = 8'h00;
      end
      test_reset();
      test_fixed_message();
      test_random_messages();
      test_start_ignored();
      test_reset_midframe();
      test_start_held();
      test_msg_len1();
      test_rom_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rom_uart_tx.md
ROM_UART_TX -- requirements
Module: rom_uart_tx

Interface
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 434, CLOCK cycles per serial bit (115200 baud at 50 MHz).
REQ-002 The block SHALL provide parameter MSG_LEN, default 10, number of bytes sent per message.
REQ-003 The block SHALL provide parameter ADDR_W, default 4, width of rom_addr.
REQ-004 The block SHALL have port CLOCK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request to send one message.
REQ-007 The block SHALL have port rom_addr, output, ADDR_W bits: byte address to an external ROM with one-cycle registered read latency.
REQ-008 The block SHALL have port rom_data, input, 8 bits: ROM output for rom_addr presented one edge earlier.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of message.

Function
REQ-012 States SHALL be IDLE, FETCH, LOAD, START, DATA, STOP; encoding is free.
REQ-013 In IDLE, start=1 at an edge SHALL set rom_addr=0 and state=FETCH; start=0 keeps IDLE.
REQ-014 FETCH SHALL last exactly 1 cycle (ROM read latency), then go to LOAD.
REQ-015 LOAD SHALL last 1 cycle, capture rom_data into an 8-bit shift register on its exiting edge, then go to START.
REQ-016 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive shift register bit 0 for CLKS_PER_BIT cycles per bit, shifting right after each bit; exactly 8 bits; 3-bit bit counter, no wrap beyond 7.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-019 At STOP end with rom_addr < MSG_LEN-1: rom_addr SHALL increment by 1 and state SHALL go to FETCH; no idle gap beyond FETCH+LOAD (2 cycles of tx=1).
REQ-020 At STOP end with rom_addr = MSG_LEN-1: done SHALL pulse high for exactly the next cycle, state SHALL return to IDLE, rom_addr SHALL hold its value.
REQ-021 Baud counter SHALL be wide enough for CLKS_PER_BIT-1, count 0..CLKS_PER_BIT-1, and clear at every state entry.
REQ-022 start SHALL be ignored while busy=1; no queuing.
REQ-023 start held high continuously SHALL start a new message on the first edge in IDLE after done.
REQ-024 tx SHALL be registered, glitch-free, and =1 in IDLE, FETCH, LOAD.
REQ-025 MSG_LEN=1 SHALL send one byte from address 0 then pulse done.
REQ-026 rom_data SHALL be sampled only on the LOAD exiting edge; changes at other times have no effect.

Reset
REQ-027 RESET_N=0 SHALL immediately, without a clock edge, force state=IDLE, tx=1, busy=0, done=0, rom_addr=0, shift register=0, all counters=0.
REQ-028 Reset mid-frame SHALL abort the byte with no further bits; after release the block waits in IDLE for start.
REQ-029 Release of RESET_N SHALL take effect at the first rising CLOCK edge with RESET_N=1.

Verification
REQ-030 Bench SHALL cover: CLKS_PER_BIT=4, MSG_LEN=10, ROM {66, 139 x9}, start pulse -> tx frames 0,01000010(LSB first),1 then nine frames of 139; done pulses once, 2+40 cycles after the final FETCH entry.
REQ-031 Bench SHALL cover: start pulsed during DATA of byte 3 -> no effect; message still ends after exactly 10 bytes, single done pulse.
REQ-032 Bench SHALL cover: RESET_N low during DATA bit 5 of byte 2 -> tx=1, busy=0, rom_addr=0 before the next edge; new start sends from address 0.
REQ-033 Bench SHALL cover: start held high for 3 messages -> three done pulses, each followed by IDLE for exactly 1 cycle before FETCH.
REQ-034 Bench SHALL cover: MSG_LEN=1, ROM[0]=8'hA5 -> single frame 0,10100101,1; rom_addr stays 0; done pulses once.
REQ-035 Bench SHALL cover: rom_data changed to 8'hFF except on the LOAD exiting edge -> transmitted bytes match the ROM contents only.
